// File: rtl/pipeline_trace_buffer_if.sv
// Readout port of the pipeline trace buffer: oldest-first valid/ready stream.
interface pipeline_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int TS_W   = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_kind;
    logic [REG_AW-1:0] rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;

    modport master (
        output rd_valid, rd_kind, rd_tag, rd_data, rd_ts,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_kind, rd_tag, rd_data, rd_ts,
        output rd_ready
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Trace capture beside the TessiaX32 core: records writeback register writes
// and taken branches into a circular buffer with pre-trigger history, a
// programmable trigger and post-trigger count, then drains oldest-first.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   S_IDLE     | no capture, buffer empty, readout disabled
//   S_ARMED    | capturing history (overwrite oldest), watching trigger
//   S_TRIG     | capturing, counting down post-trigger entries
//   S_DONE     | capture frozen, buffer drained over the rd port
module pipeline_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_on_reg,
    input  logic [REG_AW-1:0] trig_reg,
    input  logic              trig_on_branch,
    input  logic [CNT_W-1:0]  post_count,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_branch,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [3:0]        ex_flags,
    pipeline_trace_buffer_if.master rd,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_MAX_C = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [TS_W-1:0]  TS_ONE     = TS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [7:0]        dropped_q, dropped_d;
    logic [TS_W-1:0]   ts_q, ts_d;

    logic              mem_kind_q [DEPTH];
    logic [REG_AW-1:0] mem_tag_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [TS_W-1:0]   mem_ts_q   [DEPTH];

    logic              wr_en;
    logic [REG_AW-1:0] flags_tag;
    logic [REG_AW-1:0] wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              ev_any;
    logic              trig_hit;
    logic [CNT_W-1:0]  post_clamped;
    logic              rd_valid_int;
    logic              pop;

    // Branch flags are zero-extended or truncated to fit the tag field.
    always_comb begin
        flags_tag = '0;
        for (int i = 0; i < REG_AW && i < 4; i++) begin
            flags_tag[i] = ex_flags[i];
        end
    end

    assign wr_tag       = wb_we ? wb_reg  : flags_tag;
    assign wr_data      = wb_we ? wb_data : ex_target;
    assign ev_any       = wb_we | ex_branch;
    assign trig_hit     = (trig_on_reg & wb_we & (wb_reg == trig_reg)) | (trig_on_branch & ex_branch);
    assign post_clamped = (post_count > POST_MAX_C) ? POST_MAX_C : post_count;
    assign rd_valid_int = (state_q == S_DONE) && (count_q != '0);
    assign pop          = rd_valid_int & rd.rd_ready;

    // Next-state: abort beats arm; capture in ARMED/TRIG, pop in DONE.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        remain_d  = remain_q;
        dropped_d = dropped_q;
        ts_d      = ts_q + TS_ONE;
        wr_en     = 1'b0;
        if (abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (arm) begin
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            dropped_d = '0;
        end else begin
            case (state_q)
                S_ARMED, S_TRIG: begin
                    if (ev_any) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        // Full buffer keeps the newest DEPTH entries.
                        if (count_q == DEPTH_C) begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                        if (wb_we && ex_branch && (dropped_q != 8'hFF)) begin
                            dropped_d = dropped_q + 8'd1;
                        end
                        if (state_q == S_ARMED) begin
                            if (trig_hit) begin
                                remain_d = post_clamped;
                                state_d  = (post_clamped == '0) ? S_DONE : S_TRIG;
                            end
                        end else begin
                            remain_d = remain_q - CNT_ONE;
                            if (remain_q == CNT_ONE) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            remain_q  <= '0;
            dropped_q <= '0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            remain_q  <= remain_d;
            dropped_q <= dropped_d;
            ts_q      <= ts_d;
        end
    end

    // Entry storage; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_kind_q[wr_ptr_q] <= ~wb_we;
            mem_tag_q[wr_ptr_q]  <= wr_tag;
            mem_data_q[wr_ptr_q] <= wr_data;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end

    assign rd.rd_valid = rd_valid_int;
    assign rd.rd_kind  = rd_valid_int ? mem_kind_q[rd_ptr_q] : 1'b0;
    assign rd.rd_tag   = rd_valid_int ? mem_tag_q[rd_ptr_q]  : '0;
    assign rd.rd_data  = rd_valid_int ? mem_data_q[rd_ptr_q] : '0;
    assign rd.rd_ts    = rd_valid_int ? mem_ts_q[rd_ptr_q]   : '0;

    assign state   = state_q;
    assign count   = count_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: queue-based reference model plus a
// scoreboard monitor on the readout port.
module tb_pipeline_trace_buffer;
    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              arm = 1'b0, abort = 1'b0;
    logic              trig_on_reg = 1'b0, trig_on_branch = 1'b0;
    logic [REG_AW-1:0] trig_reg = '0;
    logic [CNT_W-1:0]  post_count = '0;
    logic              wb_we = 1'b0, ex_branch = 1'b0;
    logic [REG_AW-1:0] wb_reg = '0;
    logic [DATA_W-1:0] wb_data = '0, ex_target = '0;
    logic [3:0]        ex_flags = '0;
    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [7:0]        dropped;

    pipeline_trace_buffer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TS_W(TS_W)) rd_if ();

    pipeline_trace_buffer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_on_reg(trig_on_reg), .trig_reg(trig_reg), .trig_on_branch(trig_on_branch),
        .post_count(post_count), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_branch(ex_branch), .ex_target(ex_target), .ex_flags(ex_flags),
        .rd(rd_if.master), .state(state), .count(count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is just a bounded queue of entries.
    typedef struct {
        logic              kind;
        logic [REG_AW-1:0] tag;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } ent_t;

    ent_t m_q[$];
    int   m_state   = 0;
    int   m_dropped = 0;
    int   m_remain  = 0;
    int   m_ts      = 0;

    task automatic model_step();
        ent_t e;
        bit   ev, hit;
        int   p;
        if (abort) begin
            m_q.delete();
            m_state = 0;
        end else if (arm) begin
            m_q.delete();
            m_dropped = 0;
            m_state = 1;
        end else if (m_state == 1 || m_state == 2) begin
            ev = wb_we || ex_branch;
            if (ev) begin
                e.kind = !wb_we;
                e.tag  = wb_we ? wb_reg : ex_flags;
                e.data = wb_we ? wb_data : ex_target;
                e.ts   = TS_W'(m_ts);
                if (m_q.size() == DEPTH) void'(m_q.pop_front());
                m_q.push_back(e);
                if (wb_we && ex_branch && m_dropped < 255) m_dropped++;
            end
            if (m_state == 1) begin
                hit = (trig_on_reg && wb_we && wb_reg == trig_reg) || (trig_on_branch && ex_branch);
                if (hit) begin
                    p = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                    m_remain = p;
                    m_state = (p == 0) ? 3 : 2;
                end
            end else if (ev) begin
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_state = 0;
            m_dropped = 0;
            m_remain = 0;
            m_ts = 0;
        end else begin
            model_step();
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    // Scoreboard monitor: peek the expected oldest entry whenever valid, pop on handshake.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            chk("rd_valid", rd_if.rd_valid, (m_state == 3 && m_q.size() != 0));
            if (rd_if.rd_valid && m_q.size() != 0) begin
                chk("rd_kind", rd_if.rd_kind, m_q[0].kind);
                chk("rd_tag",  rd_if.rd_tag,  m_q[0].tag);
                chk("rd_data", rd_if.rd_data, m_q[0].data);
                chk("rd_ts",   rd_if.rd_ts,   m_q[0].ts);
                if (rd_if.rd_ready) begin
                    void'(m_q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wb(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        wb_we = 1'b1; wb_reg = r; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic check_model(input string n);
        chk({n, "_state"},   state,   m_state);
        chk({n, "_count"},   count,   m_q.size());
        chk({n, "_dropped"}, dropped, m_dropped);
    endtask

    task automatic drain(input string n, input bit rand_ready);
        for (int i = 0; i < 4 * DEPTH + 16 && rd_if.rd_valid; i++) begin
            rd_if.rd_ready = (rand_ready && i < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        rd_if.rd_ready = 1'b0;
        chk({n, "_drained"}, rd_if.rd_valid, 1'b0);
        chk({n, "_count0"},  count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rd_if.rd_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_state",   state, 0);
        chk("rst_count",   count, 0);
        chk("rst_valid",   rd_if.rd_valid, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_ts",      rd_if.rd_ts, 0);

        // Basic register trigger with one post-trigger entry.
        trig_on_reg = 1'b1; trig_reg = 4'd2; post_count = 4'd1;
        do_arm();
        wb(4'd1, 32'd5); wb(4'd2, 32'd7); wb(4'd3, 32'd9);
        chk("basic_state", state, 3);
        chk("basic_count", count, 3);
        check_model("basic");
        drain("basic", 1'b0);

        // Wrap: ten writebacks into eight entries, then a branch trigger.
        trig_on_reg = 1'b0;
        do_arm();
        for (int i = 0; i < 10; i++) wb(REG_AW'(i), DATA_W'(100 + i));
        trig_on_branch = 1'b1; post_count = 4'd0;
        ex_branch = 1'b1; ex_target = 32'h40; ex_flags = 4'b1010;
        step();
        ex_branch = 1'b0;
        chk("wrap_state", state, 3);
        chk("wrap_count", count, 8);
        chk("wrap_first", rd_if.rd_data, 103);
        drain("wrap", 1'b0);

        // Collision: writeback wins, branch dropped but still triggers.
        do_arm();
        wb_we = 1'b1; wb_reg = 4'd4; wb_data = 32'h11;
        ex_branch = 1'b1; ex_target = 32'h80;
        step();
        wb_we = 1'b0; ex_branch = 1'b0;
        chk("coll_dropped", dropped, 1);
        chk("coll_state",   state, 3);
        chk("coll_count",   count, 1);
        drain("coll", 1'b0);

        // Backpressure with three held entries.
        trig_on_branch = 1'b0; trig_on_reg = 1'b1; trig_reg = 4'd3; post_count = 4'd0;
        do_arm();
        wb(4'd1, 32'hA1); wb(4'd2, 32'hA2); wb(4'd3, 32'hA3);
        rd_if.rd_ready = 1'b0;
        repeat (4) step();
        chk("bp_count", count, 3);
        p0 = pops;
        rd_if.rd_ready = 1'b1; step();
        rd_if.rd_ready = 1'b0; step();
        rd_if.rd_ready = 1'b1; step();
        step();
        rd_if.rd_ready = 1'b0;
        chk("bp_pops",  pops - p0, 3);
        chk("bp_valid", rd_if.rd_valid, 0);
        chk("bp_state", state, 3);

        // Abort during TRIGGERED, and abort beating arm.
        trig_reg = 4'd2; post_count = 4'd5;
        do_arm();
        wb(4'd2, 32'h1); wb(4'd5, 32'h2);
        chk("abt_trig", state, 2);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abt_state", state, 0);
        chk("abt_count", count, 0);
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        chk("abt_arm_state", state, 0);

        // Asynchronous reset mid-ARMED.
        trig_on_reg = 1'b0;
        do_arm();
        wb(4'd1, 32'h1);
        wb_we = 1'b1; ex_branch = 1'b1; step(); wb_we = 1'b0; ex_branch = 1'b0;
        chk("ares_pre", dropped, 1);
        #2 reset = 1'b0;
        #1;
        chk("ares_state",   state, 0);
        chk("ares_count",   count, 0);
        chk("ares_dropped", dropped, 0);
        chk("ares_valid",   rd_if.rd_valid, 0);
        chk("ares_kind",    rd_if.rd_kind, 0);
        chk("ares_tag",     rd_if.rd_tag, 0);
        chk("ares_data",    rd_if.rd_data, 0);
        chk("ares_ts",      rd_if.rd_ts, 0);
        step(); step();
        reset = 1'b1;
        step();

        // Randomized capture rounds against the model.
        for (int r = 0; r < 8; r++) begin
            trig_on_reg    = 1'($urandom_range(0, 1));
            trig_on_branch = 1'($urandom_range(0, 1));
            trig_reg       = REG_AW'($urandom);
            post_count     = CNT_W'($urandom_range(0, 15));
            do_arm();
            for (int c = 0; c < 30; c++) begin
                wb_we     = ($urandom_range(0, 2) != 0);
                ex_branch = ($urandom_range(0, 3) == 0);
                wb_reg    = REG_AW'($urandom);
                wb_data   = $urandom;
                ex_target = $urandom;
                ex_flags  = 4'($urandom);
                rd_if.rd_ready = 1'($urandom_range(0, 1));
                step();
            end
            wb_we = 1'b0; ex_branch = 1'b0; rd_if.rd_ready = 1'b0;
            check_model($sformatf("rnd%0d", r));
            if (state == 2'd3) drain($sformatf("rnd%0d", r), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
Synthesizable on-chip trace capture for the TessiaX32 pipeline. It records writeback register writes and taken branches from execute into a circular buffer, with a pre-trigger history window, a programmable trigger and a post-trigger count. After capture stops, software or debug logic drains the buffer oldest-first over a valid/ready port. It sits beside the core and observes the writeback and execute stages without affecting them.

Parameters:
DATA_W, 32, width of writeback data and branch target
REG_AW, 4, register index width
DEPTH, 16, buffer entries (power of two, >=4)
TS_W, 16, timestamp width
CNT_W, $clog2(DEPTH)+1, width of count/post_count

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state
arm  in  1  pulse: clear buffer, enter ARMED
abort  in  1  pulse: clear buffer, enter IDLE
trig_on_reg  in  1  trigger enable: writeback to trig_reg
trig_reg  in  REG_AW  trigger register index
trig_on_branch  in  1  trigger enable: taken branch
post_count  in  CNT_W  entries captured after trigger entry; sampled on trigger
wb_we  in  1  writeback register write strobe
wb_reg  in  REG_AW  writeback destination
wb_data  in  DATA_W  writeback value
ex_branch  in  1  branch taken in execute
ex_target  in  DATA_W  branch target (ALU result)
ex_flags  in  4  ALU flags NZCV
rd_valid  out  1  oldest entry available
rd_ready  in  1  consumer accepts entry
rd_kind  out  1  0=writeback, 1=branch
rd_tag  out  REG_AW  wb_reg, or ex_flags zero-extended/truncated to REG_AW
rd_data  out  DATA_W  wb_data or ex_target
rd_ts  out  TS_W  timestamp at capture
state  out  2  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3
count  out  CNT_W  valid entries held
dropped  out  8  branches lost to collisions, saturates at 255

Behaviour:
- Reset (reset=0, async): state IDLE, count 0, pointers 0, timestamp 0, dropped 0, rd_valid 0; rd_kind/rd_tag/rd_data/rd_ts 0.
- Timestamp: free-running from reset, +1 per cycle, wraps modulo 2^TS_W. Entry ts = value in the cycle the event is presented.
- Event selection per cycle (only in ARMED/TRIGGERED): wb_we takes the write slot. If ex_branch is also asserted, the branch is not stored and dropped increments (saturating). Otherwise ex_branch is stored. At most one write per cycle.
- Capture latency: an event at edge N is reflected in count/buffer after edge N.
- Full in ARMED/TRIGGERED: overwrite oldest; count holds DEPTH; not counted as a drop.
- Trigger (ARMED only): (trig_on_reg & wb_we & wb_reg==trig_reg) | (trig_on_branch & ex_branch).
  - A branch trigger fires even when the branch entry is dropped by collision.
  - The triggering cycle's stored entry is captured.
  - post_count is latched, clamped to DEPTH-1.
  - If the latched value is 0, go to DONE; else go to TRIGGERED.
- TRIGGERED: each stored entry decrements the remaining count. The entry that brings it to 0 is stored, then go to DONE. Cycles without events do not decrement.
- DONE: no capture; inputs are ignored except arm/abort/readout.
  - rd_valid = (count!=0). Outputs present the oldest entry combinationally from the read pointer.
  - On rd_valid&rd_ready, pop at the edge. Outputs hold stable while rd_valid&!rd_ready.
  - At count 0 remain in DONE.
- rd_valid is 0 in IDLE/ARMED/TRIGGERED.
- arm (any state): clear pointers/count/dropped, go to ARMED next edge. The arm cycle's event is not captured.
- abort (any state): clear pointers/count, go to IDLE. abort wins over a simultaneous arm.
- Reset mid-capture or mid-readout: immediate full clear; no partial entry survives.

Test Plan:
- Reset: hold reset=0 3 cycles then release -> state 0, count 0, rd_valid 0, dropped 0, rd_ts 0.
- Basic trigger (DEPTH=8): arm; trig_on_reg=1, trig_reg=2, post_count=1; writebacks r1=5, r2=7, r3=9 in consecutive cycles -> state 3 after r3, count 3. Readout gives kind 0, tags 1/2/3, data 5/7/9, ts strictly +1 apart.
- Wrap: arm; writebacks r0..r9 with data 100..109; then branch ex_target=0x40 with trig_on_branch=1, post_count=0 -> DONE, count 8. Readout data 103..109 then kind 1, data 0x40.
- Collision: ARMED, trig_on_branch=1, wb_we and ex_branch same cycle (wb r4=0x11) -> only wb stored, dropped=1, trigger fires, state DONE (post 0).
- Backpressure: DONE with 3 entries, rd_ready low 4 cycles -> rd_* stable, count 3. Toggle rd_ready 1/0/1/1 -> exactly 3 pops, then rd_valid 0, state 3.
- Abort/reset: abort during TRIGGERED -> IDLE, count 0. Arm then assert reset mid-ARMED (not on a clock edge) -> all outputs 0 immediately.
